// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if
//   Byte-stream link between the UART RX/TX ports and the register bridge.
//   rx_data/rx_valid : received byte, 1-cycle valid pulse, no backpressure
//   tx_data/tx_valid : response byte, held stable while tx_valid=1
//   tx_ready         : transmitter idle; falls when it accepts a byte
//   master : the UART side (drives rx_*, tx_ready)
//   slave  : the bridge side (drives tx_data, tx_valid)
interface uart_reg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Command responder behind a UART byte stream. Decodes host commands
//     'W'(57h), addr, data -> write register, respond 'K'(4Bh)
//     'R'(52h), addr       -> respond with register contents
//   and answers 'E'(45h) for an unknown opcode or an address >= REG_COUNT.
//   Exactly one response byte is returned per completed command.
// Ports
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : uart_reg_bridge_if.slave (rx byte in, tx byte out)
//   regs_flat    : register bank, reg[i] = regs_flat[8*i +: 8]
//   wr_strobe    : 1-cycle pulse per committed write
//   wr_addr      : address of the last committed write
//   busy         : high whenever a command or response is in progress
module uart_reg_bridge #(
    parameter int unsigned  REG_COUNT      = 16,
    parameter int unsigned  TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]   RESET_VAL      = 8'h00,
    localparam int unsigned ADDR_W         = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    uart_reg_bridge_if.slave       bus,
    output logic [REG_COUNT*8-1:0] regs_flat,
    output logic                   wr_strobe,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic                   busy
);

    localparam logic [7:0] OP_W   = 8'h57;
    localparam logic [7:0] OP_R   = 8'h52;
    localparam logic [7:0] RSP_OK = 8'h4B;
    localparam logic [7:0] RSP_ER = 8'h45;

    localparam int unsigned    CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]     REG_LIMIT = 9'(REG_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_RESP,
        S_ACK
    } state_t;

    state_t             state_q, state_d;

    logic [7:0]         regs_q [REG_COUNT];
    logic               is_write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               addr_ok_q;
    logic [7:0]         data_q;
    logic [7:0]         resp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  wr_addr_q;

    logic               op_load, addr_load, data_load, resp_load;
    logic               wr_addr_load, commit;
    logic               cnt_clr, cnt_inc;
    logic [7:0]         resp_d;

    // Full 8-bit compare: an address such as 13h must not alias onto 03h.
    logic               rx_addr_ok;
    assign rx_addr_ok = ({1'b0, bus.rx_data} < REG_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        op_load      = 1'b0;
        addr_load    = 1'b0;
        data_load    = 1'b0;
        resp_load    = 1'b0;
        resp_d       = resp_q;
        wr_addr_load = 1'b0;
        commit       = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.rx_valid) begin
                    if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
                        op_load = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        resp_load = 1'b1;
                        resp_d    = RSP_ER;
                        state_d   = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (bus.rx_valid) begin
                    cnt_clr   = 1'b1;
                    addr_load = 1'b1;
                    if (is_write_q) begin
                        state_d = S_DATA;
                    end else begin
                        resp_load = 1'b1;
                        resp_d    = rx_addr_ok ? regs_q[bus.rx_data[ADDR_W-1:0]] : RSP_ER;
                        state_d   = S_RESP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    cnt_clr      = 1'b1;
                    data_load    = 1'b1;
                    wr_addr_load = addr_ok_q;
                    state_d      = S_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_EXEC: begin
                // Out-of-range writes still pass through here so every W
                // command has the same response latency.
                commit    = addr_ok_q;
                resp_load = 1'b1;
                resp_d    = addr_ok_q ? RSP_OK : RSP_ER;
                state_d   = S_RESP;
            end
            S_RESP: begin
                if (!bus.tx_ready) state_d = S_ACK;
            end
            S_ACK: begin
                if (bus.tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
            addr_ok_q  <= 1'b0;
            data_q     <= '0;
            resp_q     <= '0;
            cnt_q      <= '0;
            wr_addr_q  <= '0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            if (op_load) is_write_q <= (bus.rx_data == OP_W);
            if (addr_load) begin
                addr_q    <= bus.rx_data[ADDR_W-1:0];
                addr_ok_q <= rx_addr_ok;
            end
            if (data_load)    data_q    <= bus.rx_data;
            if (resp_load)    resp_q    <= resp_d;
            // Loaded on entry to S_EXEC so wr_addr is valid alongside wr_strobe.
            if (wr_addr_load) wr_addr_q <= addr_q;
            if (cnt_clr)      cnt_q     <= '0;
            else if (cnt_inc) cnt_q     <= cnt_q + 1'b1;
            if (commit)       regs_q[addr_q] <= data_q;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign bus.tx_data  = resp_q;
    assign bus.tx_valid = (state_q == S_RESP);
    assign wr_strobe    = commit;
    assign wr_addr      = wr_addr_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
//   Directed and random commands against uart_reg_bridge, checked against a
//   register-array reference model of the command protocol.
module tb_uart_reg_bridge;

    localparam int unsigned NREG = 16;
    localparam int unsigned TO   = 64;

    localparam logic [7:0] C_W = 8'h57;
    localparam logic [7:0] C_R = 8'h52;
    localparam logic [7:0] C_K = 8'h4B;
    localparam logic [7:0] C_E = 8'h45;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NREG*8-1:0]  regs_flat;
    logic               wr_strobe;
    logic [3:0]         wr_addr;
    logic               busy;

    uart_reg_bridge_if bus();

    uart_reg_bridge #(
        .REG_COUNT      (NREG),
        .TIMEOUT_CYCLES (TO),
        .RESET_VAL      (8'h00)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .regs_flat (regs_flat),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         strobe_cnt = 0;
    logic [3:0] strobe_addr = '0;
    int         txv_rise = 0;
    logic       txv_prev = 1'b0;
    logic [7:0] model [NREG];

    // Observed on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cnt++;
            strobe_addr = wr_addr;
        end
        if (bus.tx_valid === 1'b1 && !txv_prev) txv_rise++;
        txv_prev = (bus.tx_valid === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic wait_resp(input string tag, input logic [7:0] exp, input int lat);
        int c;
        c = 0;
        while (bus.tx_valid !== 1'b1 && c < 20) begin
            tick(1);
            c++;
        end
        chk({tag, " valid"}, 32'(bus.tx_valid), 32'd1);
        chk({tag, " latency"}, 32'(c), 32'(lat));
        chk({tag, " data"}, 32'(bus.tx_data), 32'(exp));
    endtask

    task automatic accept(input string tag);
        tick(int'($urandom_range(0, 3)));
        bus.tx_ready = 1'b0;
        tick(1);
        chk({tag, " drop"}, 32'(bus.tx_valid), 32'd0);
        tick(2);
        chk({tag, " no reassert"}, 32'(bus.tx_valid), 32'd0);
        bus.tx_ready = 1'b1;
        tick(1);
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("%s reg%0d", tag, i), 32'(regs_flat[8*i +: 8]), 32'(model[i]));
        end
    endtask

    // Reference: a command is judged purely on opcode, 8-bit address and the
    // register array contents.
    task automatic do_cmd(input string tag, input logic [7:0] op,
                          input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] exp;
        int         lat;
        int         s0;
        int         wrote;
        wrote = 0;
        s0    = strobe_cnt;
        if (op == C_W) begin
            send(op); send(addr); send(data);
            lat = 1;
            if (int'(addr) < NREG) begin
                exp = C_K;
                model[addr] = data;
                wrote = 1;
            end else begin
                exp = C_E;
            end
        end else if (op == C_R) begin
            send(op); send(addr);
            lat = 0;
            exp = (int'(addr) < NREG) ? model[addr] : C_E;
        end else begin
            send(op);
            lat = 0;
            exp = C_E;
        end
        wait_resp(tag, exp, lat);
        accept(tag);
        chk({tag, " strobes"}, 32'(strobe_cnt - s0), 32'(wrote));
        if (wrote == 1) chk({tag, " wr_addr"}, 32'(strobe_addr), 32'(addr[3:0]));
    endtask

    initial begin
        logic [7:0] op, addr, data;
        int         r, rise0, s0;
        logic       stable;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;

        reset_n = 1'b0;
        tick(3);
        chk("rst tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk_regs("rst");
        reset_n = 1'b1;
        tick(2);

        do_cmd("w3", C_W, 8'h03, 8'hA5);
        chk_regs("after w3");
        do_cmd("r3", C_R, 8'h03, 8'h00);
        do_cmd("r7", C_R, 8'h07, 8'h00);
        do_cmd("badop", 8'h11, 8'h00, 8'h00);
        do_cmd("w10", C_W, 8'h10, 8'hFF);
        do_cmd("r13", C_R, 8'h13, 8'h00);
        do_cmd("w83", C_W, 8'h83, 8'h5A);
        do_cmd("wF", C_W, 8'h0F, 8'h5C);
        do_cmd("rF", C_R, 8'h0F, 8'h00);
        chk_regs("after bounds");

        // Timeout in S_DATA: abort exactly TO cycles after the addr byte.
        rise0 = txv_rise;
        send(C_W); send(8'h02);
        tick(int'(TO) - 1);
        chk("to busy before", 32'(busy), 32'd1);
        tick(1);
        chk("to busy after", 32'(busy), 32'd0);
        tick(20);
        chk("to no tx", 32'(txv_rise - rise0), 32'd0);
        chk_regs("after timeout");
        do_cmd("r2", C_R, 8'h02, 8'h00);

        // A byte on the expiry cycle is taken instead of aborting.
        s0 = strobe_cnt;
        send(C_W); send(8'h06);
        tick(int'(TO) - 1);
        send(8'h3C);
        model[6] = 8'h3C;
        wait_resp("edge w6", C_K, 1);
        accept("edge w6");
        chk("edge w6 strobes", 32'(strobe_cnt - s0), 32'd1);
        send(C_R);
        tick(int'(TO) - 1);
        send(8'h06);
        wait_resp("edge r6", 8'h3C, 0);
        accept("edge r6");

        // Long response hold with stray rx traffic that must be ignored.
        rise0 = txv_rise;
        send(C_R); send(8'h03);
        wait_resp("hold", 8'hA5, 0);
        stable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            bus.rx_valid = (i % 37 == 5);
            bus.rx_data  = (i % 2 == 0) ? C_W : 8'($urandom);
            tick(1);
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) stable = 1'b0;
        end
        bus.rx_valid = 1'b0;
        chk("hold stable", 32'(stable), 32'd1);
        accept("hold");
        chk("hold one byte", 32'(txv_rise - rise0), 32'd1);
        chk_regs("after hold");
        do_cmd("w8", C_W, 8'h08, 8'h77);
        do_cmd("r8", C_R, 8'h08, 8'h00);

        // Random command mix.
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      op = C_W;
            else if (r < 8) op = C_R;
            else begin
                op = 8'($urandom);
                while (op == C_W || op == C_R) op = 8'($urandom);
            end
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            data = 8'($urandom);
            do_cmd($sformatf("rnd%0d", k), op, addr, data);
        end
        chk_regs("after random");

        // Reset while waiting for the data byte.
        do_cmd("w3b", C_W, 8'h03, 8'hC3);
        rise0 = txv_rise;
        send(C_W); send(8'h05);
        chk("mid busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #2;
        chk("mid rst tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("mid rst tx_data", 32'(bus.tx_data), 32'd0);
        chk("mid rst wr_strobe", 32'(wr_strobe), 32'd0);
        chk("mid rst wr_addr", 32'(wr_addr), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        for (int i = 0; i < NREG; i++) model[i] = 8'h00;
        chk_regs("mid rst");
        tick(2);
        reset_n = 1'b1;
        tick(10);
        chk("mid rst no tx", 32'(txv_rise - rise0), 32'd0);
        chk("mid rst idle", 32'(busy), 32'd0);
        do_cmd("post r3", C_R, 8'h03, 8'h00);
        do_cmd("post w5", C_W, 8'h05, 8'h99);
        do_cmd("post r5", C_R, 8'h05, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
